sram_8192x32_rf_model: RTL and testbench
========================================

// Module: sram_8192x32_rf_model
// PURPOSE
//  Behavioural model of the 8192-word x 32-bit single-port register-file SRAM macro.
//  Four instances form each bank of the 32Kx32 (128KB) SoC SRAM.
//  Supports synchronous read, bit-masked synchronous write, and a registered output.
//  Margin, pulse and bypass trim pins are accepted and have no functional effect.
// PARAMETERS
//  DEPTH   8192  words in the array
//  ADDR_W  13    address width, log2(DEPTH)
//  DATA_W  32    word width; also the wbeb mask width
// PORTS
//  clk       in   1       clock; all array activity happens on the rising edge
//  rst       in   1       async active-high reset, clears q only
//  ren       in   1       read enable, active high
//  wen       in   1       write enable, active high
//  adr       in   13      word address
//  din       in   32      write data
//  wbeb      in   32      bit write-enable, active LOW (bit i written when wbeb[i]=0)
//  fwen      in   1       freeze: when high, the array and q are frozen
//  mc        in   3       read/write margin control; ignored
//  mcen      in   1       margin control enable; ignored
//  clkbyp    in   1       clock bypass; ignored
//  wa        in   2       write assist; ignored
//  wpulse    in   2       write pulse trim; ignored
//  wpulseen  in   1       write pulse trim enable; ignored
//  q         out  32      read data, registered
// BEHAVIOUR
//  - Reset: rst=1 drives q=0 immediately (asynchronous). Array contents are preserved.
//    While rst is held, edges perform no read and no write.
//  - Read: ren=1, wen=0, fwen=0 at edge N -> q=mem[adr] after edge N (1-cycle latency).
//  - q holds its last value in every cycle with no read, including write and idle cycles.
//  - Write: wen=1, fwen=0 at an edge -> for each bit i with wbeb[i]=0,
//    mem[adr][i]<=din[i]; bits with wbeb[i]=1 are unchanged.
//    wbeb = all ones is a legal no-op write.
//  - ren=1 and wen=1 together: the write is performed and the read is suppressed; q holds.
//  - Read of an address in the same cycle it is written: not possible, per the rule above.
//    A read on the next cycle returns the new data (no bypass needed).
//  - fwen=1: no reads and no writes; q holds. This overrides ren and wen.
//  - The full adr range 0..8191 is valid; there is no wrap or out-of-range case.
//  - Unwritten words read as X, unless SRAM_ZERO_INIT_EN is defined.
//  - Trim pins (mc, mcen, clkbyp, wa, wpulse, wpulseen) never alter data or timing.
// CONFIGURATION
//  SRAM_ZERO_INIT_EN defined: all DEPTH words are 0 at time zero; q is also 0 at time zero.
//  SRAM_ZERO_INIT_EN undefined: array and q start at X until written or reset.
// STRUCTURE
//  Package sram_rf_pkg holds:
//   - localparams DEPTH, ADDR_W, DATA_W
//   - typedef word_t  logic [DATA_W-1:0]
//   - typedef addr_t  logic [ADDR_W-1:0]
//  Sub-module sram_rf_array: storage plus the masked write port (clk, we, adr, din, bmask).
//  The top level owns the enable decode, freeze/reset gating and the q register.
// TESTING
//  1. Write 0xDEADBEEF to adr 0x0005 with wbeb=0; read adr 5
//     -> q=0xDEADBEEF one cycle after the read edge.
//  2. adr 5 holds 0xDEADBEEF; write din=0x00000000 with wbeb=0xFFFF00FF; read
//     -> q=0xDEAD00EF.
//  3. Assert rst mid-cycle after a read
//     -> q=0 with no clock edge; a later read of adr 5 still returns the stored word.
//  4. ren=wen=1 at adr 0x1FFF with din=0x12345678, wbeb=0 -> q unchanged;
//     next read -> q=0x12345678.
//  5. fwen=1 with wen=1 to adr 5 and din=0xFFFFFFFF; then fwen=0 and read
//     -> old value returned; q held during the freeze.
//  6. Toggle mc, mcen, clkbyp, wa, wpulse, wpulseen randomly during test 1 -> identical results.

Source files
------------

// File: rtl/sram_rf_pkg.sv
// Purpose : shared geometry and word/address types for the 8192x32 register-file SRAM model.
// Latency : n/a (types, constants and a pure merge function only).
// Backpr. : n/a.
//
// Contents:
//   DEPTH, ADDR_W, DATA_W  array geometry
//   word_t, addr_t         data word and word address types
//   bit_merge()            per-bit select between an old word and new data
package sram_rf_pkg;

  localparam int DEPTH  = 8192;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // For each bit, take new_w where en is 1, otherwise keep old_w.
  // en is active-high here; the macro pin polarity is handled at the top.
  function automatic word_t bit_merge(input word_t old_w,
                                      input word_t new_w,
                                      input word_t en);
    return (old_w & ~en) | (new_w & en);
  endfunction

endpackage

// File: rtl/sram_rf_array.sv
// Purpose : 8192x32 storage with a bit-masked synchronous write port and an asynchronous read tap.
// Latency : write lands on the rising edge; rdata follows adr combinationally.
// Backpr. : none; a write is accepted on every edge where we is high.
//
// Ports:
//   clk    in   rising-edge clock for writes
//   we     in   write enable (already gated by freeze/reset at the top)
//   adr    in   word address, full 0..DEPTH-1 range valid
//   din    in   write data
//   bmask  in   bit write-enable, active HIGH (bit i written when bmask[i]=1)
//   rdata  out  current contents of mem[adr]; registered by the top level
//
// Build option: SRAM_ZERO_INIT_EN clears every word at time zero; otherwise
// unwritten words are X.
module sram_rf_array
  import sram_rf_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] bmask,
  output logic [DATA_W-1:0] rdata
);

  // The storage is intentionally unreset: only the output register of the
  // macro is affected by rst, the array contents survive it.
`ifdef SRAM_ZERO_INIT_EN
  word_t mem [DEPTH] = '{default: '0};
`else
  word_t mem [DEPTH];
`endif

  // Read-modify-write of the addressed word gives per-bit write control
  // without needing DATA_W separate enables on the storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= bit_merge(mem[adr], din, bmask);
    end
  end

  // The read tap is combinational; the top captures it into q only on a
  // qualified read edge, which gives the macro its 1-cycle read latency.
  assign rdata = mem[adr];

endmodule

// File: rtl/sram_8192x32_rf_model.sv
// Purpose : behavioural model of the 8192-word x 32-bit single-port register-file SRAM macro.
// Latency : read data appears on q one cycle after the read edge; writes land on the edge.
// Backpr. : none; the macro accepts one access per cycle, freeze/reset simply drop it.
//
// Ports:
//   clk       in   1   rising-edge clock for all array activity
//   rst       in   1   async active-high; clears q only, array contents kept
//   ren       in   1   read enable
//   wen       in   1   write enable (wins over ren when both are high)
//   adr       in   13  word address
//   din       in   32  write data
//   wbeb      in   32  bit write-enable, active LOW
//   fwen      in   1   freeze: blocks reads and writes, q holds
//   mc, mcen, clkbyp, wa, wpulse, wpulseen
//             in   -   margin/pulse/bypass trim pins, no functional effect
//   q         out  32  registered read data
//
// Build option: SRAM_ZERO_INIT_EN makes the array and q start at zero
// instead of X.
module sram_8192x32_rf_model
  import sram_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] wbeb,
  input  logic              fwen,
  input  logic [2:0]        mc,
  input  logic              mcen,
  input  logic              clkbyp,
  input  logic [1:0]        wa,
  input  logic [1:0]        wpulse,
  input  logic              wpulseen,
  output logic [DATA_W-1:0] q
);

  // ---------------------------------------------------------------------
  // Enable decode
  // ---------------------------------------------------------------------
  // An edge may touch the array only when neither freeze nor reset is
  // active. Reset must also block writes because the array itself has no
  // reset and would otherwise keep accepting them while rst is held.
  logic access_ok;
  logic do_write;
  logic do_read;

  assign access_ok = ~fwen & ~rst;
  assign do_write  = access_ok & wen;
  // A simultaneous read and write performs only the write; q holds.
  assign do_read   = access_ok & ren & ~wen;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  word_t rdata;
  word_t bmask;

  // Macro pin is active-low per bit; the array wants active-high enables.
  assign bmask = ~wbeb;

  sram_rf_array u_array (
    .clk   (clk),
    .we    (do_write),
    .adr   (adr),
    .din   (din),
    .bmask (bmask),
    .rdata (rdata)
  );

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  // q only changes on a qualified read or on reset, so write, idle and
  // frozen cycles all leave the last read value on the pins.
`ifdef SRAM_ZERO_INIT_EN
  word_t q_r = '0;
`else
  word_t q_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (do_read) begin
      q_r <= rdata;
    end
  end

  assign q = q_r;

  // ---------------------------------------------------------------------
  // Trim pins
  // ---------------------------------------------------------------------
  // Margin, assist, pulse and bypass controls tune the real macro's
  // circuits; in this model they are accepted and deliberately dropped.
  logic unused_trim;
  assign unused_trim = ^{mc, mcen, clkbyp, wa, wpulse, wpulseen};

endmodule

// File: tb/tb_sram_8192x32_rf_model.sv
// Directed bench for sram_8192x32_rf_model: inputs change on the falling
// edge, the DUT acts on the rising edge, q is checked on the next falling edge.
module tb_sram_8192x32_rf_model;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic [12:0] adr;
  logic [31:0] din;
  logic [31:0] wbeb;
  logic        fwen;
  logic [2:0]  mc;
  logic        mcen;
  logic        clkbyp;
  logic [1:0]  wa;
  logic [1:0]  wpulse;
  logic        wpulseen;
  logic [31:0] q;

  int checks;
  int failures;

  sram_8192x32_rf_model dut (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .wen      (wen),
    .adr      (adr),
    .din      (din),
    .wbeb     (wbeb),
    .fwen     (fwen),
    .mc       (mc),
    .mcen     (mcen),
    .clkbyp   (clkbyp),
    .wa       (wa),
    .wpulse   (wpulse),
    .wpulseen (wpulseen),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: each spends exactly one clock, returning at a falling
  // edge with the controls back to idle.
  task automatic drive_write(input logic [12:0] a, input logic [31:0] d,
                             input logic [31:0] m);
    @(negedge clk);
    wen = 1'b1; ren = 1'b0; adr = a; din = d; wbeb = m;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic drive_read(input logic [12:0] a);
    @(negedge clk);
    ren = 1'b1; wen = 1'b0; adr = a;
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic randomize_trims();
    mc       = 3'($urandom_range(0, 7));
    mcen     = 1'($urandom_range(0, 1));
    clkbyp   = 1'($urandom_range(0, 1));
    wa       = 2'($urandom_range(0, 3));
    wpulse   = 2'($urandom_range(0, 3));
    wpulseen = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 32'h0) begin
      failures++;
      $display("FAIL reset_q: q=%h expected=%h", q, 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    drive_write(13'h0005, 32'hDEADBEEF, 32'h0);
    drive_read(13'h0005);
    checks++;
    if (q !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read: q=%h expected=%h", q, 32'hDEADBEEF);
    end
  endtask

  task automatic test_bit_mask();
    drive_write(13'h0005, 32'h00000000, 32'hFFFF00FF);
    drive_read(13'h0005);
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL bit_mask: q=%h expected=%h", q, 32'hDEAD00EF);
    end
    // All-ones mask is a legal write that changes nothing.
    drive_write(13'h0005, 32'h00000000, 32'hFFFFFFFF);
    drive_read(13'h0005);
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL noop_write: q=%h expected=%h", q, 32'hDEAD00EF);
    end
  endtask

  task automatic test_async_reset();
    drive_read(13'h0005);
    // Mid-cycle assertion: q must clear without any rising edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: q=%h expected=%h", q, 32'h0);
    end
    // Edges under reset must neither read nor write.
    @(negedge clk);
    wen = 1'b1; adr = 13'h0005; din = 32'h0; wbeb = 32'h0;
    @(negedge clk);
    wen = 1'b0; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    checks++;
    if (q !== 32'h0) begin
      failures++;
      $display("FAIL reset_blocks_read: q=%h expected=%h", q, 32'h0);
    end
    rst = 1'b0;
    drive_read(13'h0005);
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL array_kept_after_reset: q=%h expected=%h", q, 32'hDEAD00EF);
    end
  endtask

  task automatic test_rw_collision();
    @(negedge clk);
    ren = 1'b1; wen = 1'b1; adr = 13'h1FFF; din = 32'h12345678; wbeb = 32'h0;
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL collision_q_hold: q=%h expected=%h", q, 32'hDEAD00EF);
    end
    drive_read(13'h1FFF);
    checks++;
    if (q !== 32'h12345678) begin
      failures++;
      $display("FAIL collision_write_done: q=%h expected=%h", q, 32'h12345678);
    end
  endtask

  task automatic test_freeze();
    @(negedge clk);
    fwen = 1'b1; wen = 1'b1; adr = 13'h0005; din = 32'hFFFFFFFF; wbeb = 32'h0;
    @(negedge clk);
    wen = 1'b0; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    checks++;
    if (q !== 32'h12345678) begin
      failures++;
      $display("FAIL freeze_q_hold: q=%h expected=%h", q, 32'h12345678);
    end
    fwen = 1'b0;
    drive_read(13'h0005);
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL freeze_blocks_write: q=%h expected=%h", q, 32'hDEAD00EF);
    end
  endtask

  task automatic test_idle_hold();
    // Write and idle cycles leave q at the last read value.
    drive_write(13'h0100, 32'hA5A5A5A5, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 32'hDEAD00EF) begin
      failures++;
      $display("FAIL idle_hold: q=%h expected=%h", q, 32'hDEAD00EF);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive writes at the two ends of the range, then consecutive
    // reads; the first read directly follows the last write.
    @(negedge clk);
    wen = 1'b1; wbeb = 32'h0; adr = 13'h0000; din = 32'h11111111;
    @(negedge clk);
    adr = 13'h1FFF; din = 32'h22222222;
    @(negedge clk);
    wen = 1'b0; ren = 1'b1; adr = 13'h1FFF;
    @(negedge clk);
    adr = 13'h0000;
    checks++;
    if (q !== 32'h22222222) begin
      failures++;
      $display("FAIL b2b_read_top: q=%h expected=%h", q, 32'h22222222);
    end
    @(negedge clk);
    adr = 13'h0100;
    checks++;
    if (q !== 32'h11111111) begin
      failures++;
      $display("FAIL b2b_read_zero: q=%h expected=%h", q, 32'h11111111);
    end
    @(negedge clk);
    ren = 1'b0;
    checks++;
    if (q !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_read_mid: q=%h expected=%h", q, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_trim_pins();
    // Same sequence as the basic write/read, with trims changing every cycle.
    @(negedge clk);
    randomize_trims();
    wen = 1'b1; adr = 13'h0AAA; din = 32'hCAFEF00D; wbeb = 32'h0;
    @(negedge clk);
    randomize_trims();
    wen = 1'b0; ren = 1'b1;
    @(negedge clk);
    randomize_trims();
    ren = 1'b0;
    checks++;
    if (q !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL trim_write_read: q=%h expected=%h", q, 32'hCAFEF00D);
    end
    @(negedge clk);
    randomize_trims();
    wen = 1'b1; adr = 13'h0AAA; din = 32'h00000000; wbeb = 32'h0000FFFF;
    @(negedge clk);
    randomize_trims();
    wen = 1'b0; ren = 1'b1;
    @(negedge clk);
    randomize_trims();
    ren = 1'b0;
    checks++;
    if (q !== 32'h0000F00D) begin
      failures++;
      $display("FAIL trim_mask: q=%h expected=%h", q, 32'h0000F00D);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; ren = 1'b0; wen = 1'b0; fwen = 1'b0;
    adr = '0; din = '0; wbeb = '1;
    mc = '0; mcen = 1'b0; clkbyp = 1'b0; wa = '0; wpulse = '0; wpulseen = 1'b0;

    test_reset();
    test_write_read();
    test_bit_mask();
    test_async_reset();
    test_rw_collision();
    test_freeze();
    test_idle_hold();
    test_back_to_back();
    test_trim_pins();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
